// File: rtl/pipe_div_pkg.sv
// Shared definitions for the pipelined signed/unsigned divider.
//   div_flags_t : per-transaction control flags that ride down the pipeline
//   div_latency : register stages from input acceptance to result (N + 2)
package pipe_div_pkg;

  typedef struct packed {
    logic sgn;    // transaction is two's complement
    logic neg_q;  // quotient must be negated at fixup
    logic neg_r;  // remainder must be negated at fixup (dividend negative)
    logic div0;   // divisor was zero
    logic ovf;    // MIN / -1
  } div_flags_t;

  function automatic int div_latency(input int dend_w, input int bits_per_stg);
    return dend_w / bits_per_stg + 2;
  endfunction

endpackage

// File: rtl/pipe_div_sx_stage.sv
// One iteration stage of the restoring divider.
// Resolves BITS_PER_STG quotient bits (MSB first) and registers the record.
//   clk, rst : clock, asynchronous active-high reset (valid bit only)
//   en       : global advance enable
//   up_*     : record from the previous stage
//   dn_*     : registered record for the next stage
module pipe_div_sx_stage
  import pipe_div_pkg::*;
#(
  parameter int DEND_W       = 32,
  parameter int SOR_W        = 32,
  parameter int BITS_PER_STG = 1,
  parameter int TAG_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              up_vld,
  input  logic [SOR_W-1:0]  up_rem,
  input  logic [DEND_W-1:0] up_quo,
  input  logic [SOR_W-1:0]  up_dsor,
  input  div_flags_t        up_flg,
  input  logic [DEND_W-1:0] up_dend,
  input  logic [TAG_W-1:0]  up_tag,
  output logic              dn_vld,
  output logic [SOR_W-1:0]  dn_rem,
  output logic [DEND_W-1:0] dn_quo,
  output logic [SOR_W-1:0]  dn_dsor,
  output div_flags_t        dn_flg,
  output logic [DEND_W-1:0] dn_dend,
  output logic [TAG_W-1:0]  dn_tag
);

  // quo holds the not-yet-consumed dividend bits at the top and collects
  // quotient bits at the bottom; one shift per step moves both.
  logic [SOR_W:0]   rem_w;
  logic [DEND_W-1:0] quo_w;
  logic [SOR_W+1:0] diff_w;

  always_comb begin
    rem_w  = {1'b0, up_rem};
    quo_w  = up_quo;
    diff_w = '0;
    for (int b = 0; b < BITS_PER_STG; b++) begin
      rem_w  = {rem_w[SOR_W-1:0], quo_w[DEND_W-1]};
      quo_w  = {quo_w[DEND_W-2:0], 1'b0};
      diff_w = {1'b0, rem_w} - {2'b00, up_dsor};
      if (!diff_w[SOR_W+1]) begin
        rem_w    = diff_w[SOR_W:0];
        quo_w[0] = 1'b1;
      end
    end
  end

  // ---- stage register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     dn_vld <= 1'b0;
    else if (en) dn_vld <= up_vld;
  end

  // After a step the partial remainder is below the divisor, so SOR_W bits
  // hold it between stages (divide-by-zero garbage is discarded at fixup).
  always_ff @(posedge clk) begin
    if (en) begin
      dn_rem  <= rem_w[SOR_W-1:0];
      dn_quo  <= quo_w;
      dn_dsor <= up_dsor;
      dn_flg  <= up_flg;
      dn_dend <= up_dend;
      dn_tag  <= up_tag;
    end
  end

endmodule

// File: rtl/pipe_div_sx.sv
// Pipelined signed/unsigned integer divider, one division per cycle.
// S0 conditions operands to magnitudes, N = DEND_W/BITS_PER_STG iteration
// stages run the restoring division, SF applies signs and special cases.
//   clk, rst            : clock, asynchronous active-high reset
//   valid_i / ready_o   : input handshake (ready_o = ~valid_o | ready_i)
//   signed_i            : 1 = two's complement operands
//   dividend_i, divisor_i, tag_i : operands and opaque sideband
//   valid_o / ready_i   : output handshake
//   quotient_o, remainder_o, div0_o, ovf_o, tag_o : result
module pipe_div_sx
  import pipe_div_pkg::*;
#(
  parameter int DEND_W       = 32,
  parameter int SOR_W        = 32,
  parameter int BITS_PER_STG = 1,
  parameter int TAG_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              signed_i,
  input  logic [DEND_W-1:0] dividend_i,
  input  logic [SOR_W-1:0]  divisor_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DEND_W-1:0] quotient_o,
  output logic [SOR_W-1:0]  remainder_o,
  output logic              div0_o,
  output logic              ovf_o,
  output logic [TAG_W-1:0]  tag_o
);

  localparam int N = div_latency(DEND_W, BITS_PER_STG) - 2;
  localparam logic [DEND_W-1:0] DEND_MIN = {1'b1, {(DEND_W-1){1'b0}}};

  if (DEND_W % BITS_PER_STG != 0) begin : g_bad_bits_per_stg
    $error("pipe_div_sx: BITS_PER_STG must divide DEND_W");
  end

  typedef struct packed {
    logic              vld;
    logic [SOR_W-1:0]  rem;
    logic [DEND_W-1:0] quo;
    logic [SOR_W-1:0]  dsor;
    div_flags_t        flg;
    logic [DEND_W-1:0] dend;
    logic [TAG_W-1:0]  tag;
  } stg_t;

  function automatic logic [DEND_W-1:0] neg_q(input logic [DEND_W-1:0] x, input logic n);
    return n ? -x : x;
  endfunction

  function automatic logic [SOR_W-1:0] neg_r(input logic [SOR_W-1:0] x, input logic n);
    return n ? -x : x;
  endfunction

  // Dividend reinterpreted at remainder width: sign fill only matters when
  // SOR_W exceeds DEND_W, otherwise this is a plain truncation.
  function automatic logic [SOR_W-1:0] div0_rem(input logic [DEND_W-1:0] d, input logic sgn);
    logic [SOR_W+DEND_W-1:0] ext;
    ext = {{SOR_W{sgn & d[DEND_W-1]}}, d};
    return ext[SOR_W-1:0];
  endfunction

  logic en;
  assign en      = ~valid_o | ready_i;
  assign ready_o = en;

  // ---- S0: operand conditioning ----
  logic signed [DEND_W-1:0] dend_s;
  logic signed [SOR_W-1:0]  dsor_s;
  logic dd_neg, ds_neg;
  stg_t s0_d;

  assign dend_s = dividend_i;
  assign dsor_s = divisor_i;
  assign dd_neg = signed_i & (dend_s < 0);
  assign ds_neg = signed_i & (dsor_s < 0);

  always_comb begin
    s0_d           = '0;
    s0_d.quo       = dd_neg ? -dividend_i : dividend_i;
    s0_d.dsor      = ds_neg ? -divisor_i : divisor_i;
    s0_d.flg.sgn   = signed_i;
    s0_d.flg.neg_q = dd_neg ^ ds_neg;
    s0_d.flg.neg_r = dd_neg;
    s0_d.flg.div0  = (divisor_i == '0);
    s0_d.flg.ovf   = signed_i & (dividend_i == DEND_MIN) & (&divisor_i);
    s0_d.dend      = dividend_i;
    s0_d.tag       = tag_i;
  end

  logic vld_p0;
  stg_t dat_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     vld_p0 <= 1'b0;
    else if (en) vld_p0 <= valid_i;
  end

  always_ff @(posedge clk) begin
    if (en) dat_p0 <= s0_d;
  end

  stg_t stg_p [0:N];

  always_comb begin
    stg_p[0]     = dat_p0;
    stg_p[0].vld = vld_p0;
  end

  // ---- iteration stages ----
  for (genvar g = 0; g < N; g++) begin : g_stg
    logic              vld_w;
    logic [SOR_W-1:0]  rem_w;
    logic [DEND_W-1:0] quo_w;
    logic [SOR_W-1:0]  dsor_w;
    div_flags_t        flg_w;
    logic [DEND_W-1:0] dend_w;
    logic [TAG_W-1:0]  tag_w;

    pipe_div_sx_stage #(
      .DEND_W       (DEND_W),
      .SOR_W        (SOR_W),
      .BITS_PER_STG (BITS_PER_STG),
      .TAG_W        (TAG_W)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .up_vld  (stg_p[g].vld),
      .up_rem  (stg_p[g].rem),
      .up_quo  (stg_p[g].quo),
      .up_dsor (stg_p[g].dsor),
      .up_flg  (stg_p[g].flg),
      .up_dend (stg_p[g].dend),
      .up_tag  (stg_p[g].tag),
      .dn_vld  (vld_w),
      .dn_rem  (rem_w),
      .dn_quo  (quo_w),
      .dn_dsor (dsor_w),
      .dn_flg  (flg_w),
      .dn_dend (dend_w),
      .dn_tag  (tag_w)
    );

    assign stg_p[g+1] = '{vld: vld_w, rem: rem_w, quo: quo_w, dsor: dsor_w,
                          flg: flg_w, dend: dend_w, tag: tag_w};
  end

  // ---- SF: sign fixup and special cases ----
  stg_t last;
  logic [DEND_W-1:0] q_d;
  logic [SOR_W-1:0]  r_d;

  assign last = stg_p[N];

  always_comb begin
    q_d = neg_q(last.quo, last.flg.neg_q);
    r_d = neg_r(last.rem, last.flg.neg_r);
    if (last.flg.div0) begin
      q_d = '1;
      r_d = div0_rem(last.dend, last.flg.sgn);
    end else if (last.flg.ovf) begin
      q_d = DEND_MIN;
      r_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o     <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
      div0_o      <= 1'b0;
      ovf_o       <= 1'b0;
      tag_o       <= '0;
    end else if (en) begin
      valid_o     <= last.vld;
      quotient_o  <= q_d;
      remainder_o <= r_d;
      div0_o      <= last.flg.div0;
      ovf_o       <= last.flg.ovf & ~last.flg.div0;
      tag_o       <= last.tag;
    end
  end

endmodule

// File: doc/pipe_div_sx.md
# pipe_div_sx

Pipelined signed/unsigned integer divider, next generation of the team's fixed-latency unsigned divider pipeline. It adds per-transaction signed mode, a configurable number of quotient bits per stage, valid/ready backpressure, a sideband tag, and divide-by-zero and overflow flags. It sits in datapaths that need one division per cycle at full throughput with deterministic latency.

## Interface
Parameters:
- DEND_W, 32, dividend and quotient width (≥2)
- SOR_W, 32, divisor and remainder width (≥2)
- BITS_PER_STG, 1, quotient bits resolved per pipeline stage; must divide DEND_W (elaboration error otherwise)
- TAG_W, 4, sideband tag width (≥1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- valid_i  in  1  input transaction valid
- ready_o  out  1  input accepted when valid_i & ready_o
- signed_i  in  1  1: operands two's complement; 0: unsigned
- dividend_i  in  DEND_W  dividend
- divisor_i  in  SOR_W  divisor
- tag_i  in  TAG_W  opaque sideband, returned with result
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts result when valid_o & ready_i
- quotient_o  out  DEND_W  quotient
- remainder_o  out  SOR_W  remainder
- div0_o  out  1  divisor was zero
- ovf_o  out  1  signed overflow (MIN / -1)
- tag_o  out  TAG_W  tag of this result

## Operation
- N = DEND_W/BITS_PER_STG iteration stages between an input-conditioning stage (S0) and an output-fixup stage (SF): N+2 register stages total.
- Global advance enable: en = ~valid_o | ready_i; ready_o = en. All stages shift together when en=1, hold when en=0. Bubbles are not compressed.
- S0: latch |dividend|, |divisor| (magnitudes when signed_i=1, raw otherwise), sign of dividend, sign of quotient (XOR of operand signs, signed only), div0 = (divisor_i==0), ovf = signed_i & dividend==MIN & divisor==all-ones, original dividend, tag.
- Iteration stage: BITS_PER_STG chained restoring steps, MSB first: shift partial remainder left one, bring in next dividend bit, subtract divisor if no borrow and set quotient bit. Partial remainder width SOR_W+1.
- SF results (priority order):
  - div0: quotient = all ones; remainder = dividend low SOR_W bits (sign-extended if signed_i and SOR_W>DEND_W, else zero-extended); div0_o=1.
  - ovf: quotient = MIN (100…0), remainder = 0, ovf_o=1.
  - signed: quotient negated if quotient sign set; remainder negated if dividend negative (truncation toward zero, remainder takes dividend sign).
  - unsigned: raw quotient/remainder.
- |MIN| = 2^(DEND_W-1) fits DEND_W unsigned bits; signed remainder magnitude < 2^(SOR_W-1), so no width growth at outputs.

## Timing
- Reset: every stage valid bit 0; valid_o=0, quotient_o=0, remainder_o=0, div0_o=0, ovf_o=0, tag_o=0; ready_o=1 immediately after reset deasserts.
- Latency: input accepted on edge k -> valid_o high after edge k+N+1 (N+2 cycles, visible N+2 cycles after acceptance, assuming ready_i=1 throughout); each cycle with en=0 adds one cycle.
- Throughput: one result per cycle while ready_i=1.
- Backpressure: valid_o=1 & ready_i=0 -> ready_o=0 same cycle (combinational from ready_i and valid_o); all outputs hold stable until accepted.
- Empty output stage: ready_o=1 regardless of ready_i.
- Reset asserted mid-operation: all in-flight transactions discarded, outputs return to reset values asynchronously.
- Data registers of invalid stages may update freely; only valid bits are reset-critical, output registers are fully reset.

## Structure
- Package pipe_div_pkg: function div_latency(DEND_W, BITS_PER_STG) returning N+2; stage record typedef (valid, partial remainder, quotient, divisor, flags, tag) parametrised by widths via localparams in the module.
- Sub-module pipe_div_sx_stage: one iteration stage, BITS_PER_STG restoring steps plus register with en, instantiated N times by generate loop.
- S0 and SF are inline in the top.

## Test plan
- Unsigned, defaults: 100 / 7 -> quotient 14, remainder 2, valid_o exactly 34 cycles after acceptance, tag preserved.
- Signed: -7 / 2 -> quotient -3, remainder -1; 7 / -2 -> -3, 1; -7 / -2 -> 3, -1.
- Divisor 0: unsigned 0x1234 / 0 -> quotient 0xFFFFFFFF, remainder 0x1234, div0_o=1; signed -5 / 0 -> quotient -1, remainder -5.
- Overflow: signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, ovf_o=1; same operands unsigned -> quotient 0, remainder 0x80000000, flags 0.
- Backpressure: 40 back-to-back inputs with incrementing tags, ready_i low 5 cycles mid-stream -> ready_o low those cycles, outputs held, all 40 results in order, none lost or duplicated; reset asserted mid-stream -> valid_o=0 immediately, no stale results after release.
- BITS_PER_STG=4, DEND_W=SOR_W=16: random signed/unsigned operands vs. reference model, latency 6 cycles.
